mux2to1: RTL and testbench
==========================

Name: mux2to1

Overview:
- Parameterised 2-to-1 word multiplexer: selects operand a or b onto output y under control of select s.
- Combinational output y is always present; a registered copy y_q with a one-cycle latency is also provided for timing-closure use.
- Used as a leaf datapath element wherever two equal-width buses share one consumer.

Parameters:
- WIDTH, 4, bit width of a, b, y, y_q (legal: >= 1)

Ports:
- clk  input  1  rising-edge clock; used only by the registered path
- rst  input  1  synchronous, active-high reset; used only by the registered path
- a    input  WIDTH  operand selected when s = 0
- b    input  WIDTH  operand selected when s = 1
- s    input  1  select
- y    output  WIDTH  combinational mux output
- y_q  output  WIDTH  registered mux output

Interface note: one clock; reset is synchronous and active-high. Ports are named clk and rst.

Behaviour:
- y = (s == 0) ? a : b, purely combinational, with zero latency.
- y has no dependence on clk or rst. It is valid whenever the inputs are stable, including during reset and before the first clock edge.
- s = X/Z: y follows normal simulator ?: semantics. No special handling is required.
- y_q: on each rising clk edge, if rst = 1 then y_q <= 0, else y_q <= (s ? b : a), sampled at that edge.
- Latency y -> y_q is exactly 1 cycle.
- Reset value: y_q = {WIDTH{1'b0}}. y is not reset.
- Reset mid-operation: y_q clears to 0 on the first edge with rst = 1. It resumes tracking on the first edge with rst = 0, showing the mux result sampled at that edge.
- Simultaneous changes of s and data within a cycle: only the values at the sampling edge matter for y_q. y follows instantaneously.
- No wrap-around or arithmetic; widths of a, b, y, y_q are identical and no truncation or extension occurs.
- There is no state machine.

Optional Feature:
- Macro: MUX2TO1_SWCNT_EN.
- Defined:
  - Adds output sw_cnt [15:0], the number of clock edges at which the registered s differs from the previous registered s (select toggles).
  - Saturates at 16'hFFFF.
  - Reset to 0 by rst. The first edge after reset does not count.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package mux2to1_pkg:
  - localparam DEFAULT_WIDTH = 4
  - localparam SWCNT_W = 16
  - SEL_A = 1'b0, SEL_B = 1'b1 select encodings
- One sub-module is natural: mux2to1_comb, the pure combinational selector (a, b, s -> y).
  - Instantiated once.
  - Its output feeds both port y and the y_q register.

Test Plan:
- a=5, b=10, s=0, no clock -> y=5 immediately. Toggle s every 5 ns -> y alternates 5, 10, 5, 10 with no delta-cycle lag.
- rst=1 for 2 cycles with a=5, b=10, s=1 -> y_q=0 throughout and y=10. Release rst -> y_q=10 one edge later.
- s=0, a=3 -> y_q=3 after 1 edge. Change a to 7 mid-cycle -> y=7 at once, y_q=7 only at the next edge.
- Assert rst mid-stream with y_q=10 -> y_q=0 at the next edge while y stays 10. Deassert -> y_q=10 at the following edge.
- WIDTH=8, a=8'hFF, b=8'h00, toggle s -> y and y_q cover all-ones and all-zeros with no truncation.
- With MUX2TO1_SWCNT_EN, toggle s on 4 consecutive edges after reset -> sw_cnt=4. Hold s -> sw_cnt stays 4. rst -> sw_cnt=0.

Source files
------------

// File: rtl/mux2to1_pkg.sv
// mux2to1_pkg
//   Shared constants for the mux2to1 block: default operand width, width of
//   the optional select-toggle counter, and the select encodings.
package mux2to1_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int SWCNT_W       = 16;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage : mux2to1_pkg

// File: rtl/mux2to1_comb.sv
// mux2to1_comb
//   Pure combinational 2-to-1 word selector.
//   Ports:
//     a  [WIDTH-1:0]  operand driven to y when s selects A
//     b  [WIDTH-1:0]  operand driven to y when s selects B
//     s               select
//     y  [WIDTH-1:0]  selected operand, zero latency
module mux2to1_comb
    import mux2to1_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    output logic [WIDTH-1:0] y
);

    // An unknown select falls through to ordinary ?: merging.
    assign y = (s == SEL_A) ? a : b;

endmodule : mux2to1_comb

// File: rtl/mux2to1.sv
// mux2to1
//   Parameterised 2-to-1 word multiplexer with a combinational output and a
//   one-cycle registered copy of the same result.
//   Optional feature macro: MUX2TO1_SWCNT_EN adds sw_cnt, a saturating count
//   of select toggles seen by the registered path.
//   Ports:
//     clk             rising-edge clock, registered path only
//     rst             synchronous active-high reset, registered path only
//     a   [WIDTH-1:0] operand selected when s = 0
//     b   [WIDTH-1:0] operand selected when s = 1
//     s               select
//     y   [WIDTH-1:0] combinational mux output (never reset)
//     y_q [WIDTH-1:0] registered mux output, reset to zero
//     sw_cnt [15:0]   select-toggle count (only with MUX2TO1_SWCNT_EN)
module mux2to1
    import mux2to1_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               s,
    output logic [WIDTH-1:0]   y,
    output logic [WIDTH-1:0]   y_q
`ifdef MUX2TO1_SWCNT_EN
    ,
    output logic [SWCNT_W-1:0] sw_cnt
`endif
);

    logic [WIDTH-1:0] y_d;

    // Single selector shared by the combinational port and the register.
    mux2to1_comb #(
        .WIDTH (WIDTH)
    ) u_comb (
        .a (a),
        .b (b),
        .s (s),
        .y (y_d)
    );

    assign y = y_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q <= '0;
        end else begin
            y_q <= y_d;
        end
    end

`ifdef MUX2TO1_SWCNT_EN
    logic               s_q;
    logic               s_d;
    logic               s_vld_q;
    logic               s_vld_d;
    logic [SWCNT_W-1:0] sw_cnt_q;
    logic [SWCNT_W-1:0] sw_cnt_d;

    // s_vld_q marks that s_q holds a real sample; the first edge out of
    // reset only loads s_q and is never counted as a toggle.
    always_comb begin
        s_d      = s;
        s_vld_d  = 1'b1;
        sw_cnt_d = sw_cnt_q;
        if (s_vld_q && (s_d != s_q) && (sw_cnt_q != {SWCNT_W{1'b1}})) begin
            sw_cnt_d = sw_cnt_q + SWCNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q      <= SEL_A;
            s_vld_q  <= 1'b0;
            sw_cnt_q <= '0;
        end else begin
            s_q      <= s_d;
            s_vld_q  <= s_vld_d;
            sw_cnt_q <= sw_cnt_d;
        end
    end

    assign sw_cnt = sw_cnt_q;
`else
    // Select-toggle counter not built in this configuration.
`endif

endmodule : mux2to1

// File: tb/tb_mux2to1.sv
// tb_mux2to1
//   Directed bench for mux2to1: a WIDTH=4 instance for the main checks and a
//   WIDTH=8 instance for all-ones / all-zeros coverage.
module tb_mux2to1;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] a, b, y, y_q;
    logic       s;
    logic [7:0] a8, b8, y8, y8_q;
    logic       s8;
    int         n_total = 0;
    int         n_bad   = 0;
`ifdef MUX2TO1_SWCNT_EN
    logic [15:0] sw_cnt;
    logic [15:0] sw_cnt8;
`endif

    always #5 clk = ~clk;

    mux2to1 #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .s   (s),
        .y   (y),
        .y_q (y_q)
`ifdef MUX2TO1_SWCNT_EN
        ,
        .sw_cnt (sw_cnt)
`endif
    );

    mux2to1 #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .a   (a8),
        .b   (b8),
        .s   (s8),
        .y   (y8),
        .y_q (y8_q)
`ifdef MUX2TO1_SWCNT_EN
        ,
        .sw_cnt (sw_cnt8)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Sample registered outputs 1 ns after the rising edge.
    task automatic edge_settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        a = 4'd5; b = 4'd10; s = 1'b0;
        a8 = 8'hFF; b8 = 8'h00; s8 = 1'b0;

        // Combinational path before any clock edge.
        #1 chk("y_s0_preclk", y, 4'd5);
        s = 1'b1; #1 chk("y_s1_preclk", y, 4'd10);
        s = 1'b0; #1 chk("y_s0_again", y, 4'd5);
        s = 1'b1; #1 chk("y_s1_again", y, 4'd10);

        // Reset held two edges with s=1.
        edge_settle();
        chk("yq_rst_e1", y_q, 4'd0);
        chk("y_in_rst", y, 4'd10);
        edge_settle();
        chk("yq_rst_e2", y_q, 4'd0);
        chk("y8q_rst", y8_q, 8'h00);
        @(negedge clk) rst = 1'b0;
        edge_settle();
        chk("yq_release", y_q, 4'd10);

        // One-cycle latency and mid-cycle data change.
        @(negedge clk) begin s = 1'b0; a = 4'd3; end
        edge_settle();
        chk("yq_a3", y_q, 4'd3);
        @(negedge clk) a = 4'd7;
        #1 chk("y_a7_now", y, 4'd7);
        chk("yq_a7_hold", y_q, 4'd3);
        edge_settle();
        chk("yq_a7_edge", y_q, 4'd7);

        // Reset asserted mid-stream.
        @(negedge clk) s = 1'b1;
        edge_settle();
        chk("yq_b10", y_q, 4'd10);
        @(negedge clk) rst = 1'b1;
        edge_settle();
        chk("yq_midrst", y_q, 4'd0);
        chk("y_midrst", y, 4'd10);
        @(negedge clk) rst = 1'b0;
        edge_settle();
        chk("yq_resume", y_q, 4'd10);

        // WIDTH=8 extremes.
        @(negedge clk) s8 = 1'b0;
        #1 chk("y8_ones", y8, 8'hFF);
        edge_settle();
        chk("y8q_ones", y8_q, 8'hFF);
        @(negedge clk) s8 = 1'b1;
        #1 chk("y8_zeros", y8, 8'h00);
        chk("y8q_ones_hold", y8_q, 8'hFF);
        edge_settle();
        chk("y8q_zeros", y8_q, 8'h00);

`ifdef MUX2TO1_SWCNT_EN
        // Select-toggle counter.
        @(negedge clk) begin rst = 1'b1; s = 1'b0; end
        edge_settle();
        chk("swcnt_rst", sw_cnt, 16'd0);
        @(negedge clk) rst = 1'b0;
        edge_settle();
        chk("swcnt_first", sw_cnt, 16'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk) s = ~s;
            edge_settle();
        end
        chk("swcnt_4", sw_cnt, 16'd4);
        for (int i = 0; i < 3; i++) edge_settle();
        chk("swcnt_hold", sw_cnt, 16'd4);
        @(negedge clk) rst = 1'b1;
        edge_settle();
        chk("swcnt_clr", sw_cnt, 16'd0);
        @(negedge clk) rst = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_mux2to1
